// File: rtl/mips_fetch_pkg.sv
// Shared widths and the prefetch entry layout for the MIPS instruction fetch front-end.
package mips_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Power-of-two synchronous FIFO with registered storage, occupancy count and a one-cycle flush.
module sync_fifo_flush #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == CntW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & ~full_o;
        rdata_o = mem_q[rd_ptr_q];
        count_o = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // The owner's credit scheme must keep pushes away from a full FIFO.
    always_ff @(posedge clk_i) begin
        if (reset_ni && !flush_i && push_i) assert (!full_o);
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: credit-limited imem requests, in-order responses buffered with PCs,
// and redirect handling that discards stale prefetched and in-flight instructions.
module ifetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [PC_W-1:0]  RESET_PC        = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              out_valid_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic [PC_W-1:0]   out_pc_o,
    input  logic              out_ready_i
);

    localparam int unsigned CntW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FifoCntW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CntW-1:0]     live_q, live_d, drop_q, drop_d;
    logic                stray_ok_q;
    logic [31:0]         pending_sum;
    logic                grant, push, pop, flush;
    logic [FifoCntW-1:0] fifo_count;
    logic                fifo_full, fifo_empty;
    fetch_entry_t        wentry, head;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        imem_req_o  = reset_ni & ~redirect_valid_i
                    & ((32'(live_q) + 32'(drop_q)) < MAX_OUTSTANDING)
                    & ((32'(fifo_count) + 32'(live_q)) < DEPTH);
        imem_addr_o = fetch_pc_q;
        grant       = imem_req_o & imem_gnt_i;
        pop         = ~fifo_empty & out_ready_i;
        out_valid_o = ~fifo_empty;
        out_inst_o  = head.inst;
        out_pc_o    = head.pc;
        wentry      = '{pc: resp_pc_q, inst: imem_rdata_i};

        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        live_d      = live_q;
        drop_d      = drop_q;
        push        = 1'b0;
        flush       = 1'b0;
        pending_sum = 32'(drop_q) + 32'(live_q);

        if (redirect_valid_i) begin
            // Everything still in flight becomes a drop; a same-cycle response retires one.
            fetch_pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[PC_W-1:2], 2'b00};
            flush      = 1'b1;
            live_d     = '0;
            if (imem_rvalid_i && pending_sum != 0) pending_sum = pending_sum - 1;
            drop_d     = CntW'(pending_sum);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (imem_rvalid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else if (live_q != '0) begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
            live_d = live_q + CntW'(grant) - CntW'(push);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            stray_ok_q <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            if (grant) stray_ok_q <= 1'b0;
        end
    end

    // Responses to requests granted before a reset may still trickle in until the first new grant.
    always_ff @(posedge clk_i) begin
        if (reset_ni && imem_rvalid_i && !redirect_valid_i && !stray_ok_q)
            assert (live_q != '0 || drop_q != '0);
    end

    sync_fifo_flush #(
        .DEPTH(DEPTH),
        .WIDTH(PC_W + INST_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: expected PCs queued by the stimulus, checked by an output monitor.
module tb_ifetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] glog_q[$];
    bit          mem_hold = 1'b0;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .out_valid_o     (out_valid),
        .out_inst_o      (out_inst),
        .out_pc_o        (out_pc),
        .out_ready_i     (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            step(1);
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_ni       = 1'b0;
        out_ready      = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        step(2);
        pend_q.delete();
        glog_q.delete();
        exp_q.delete();
    endtask

    // Memory model: grant seen before an edge, data returned for the following edge.
    initial begin
        logic        g;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            if (g) begin
                pend_q.push_back(a);
                glog_q.push_back(a);
            end
            @(posedge clk);
            #1;
            if (!mem_hold && pend_q.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_q.pop_front() ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    // Output monitor: each handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_ni && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got pc %h expected no output", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_pc", out_pc, mon_exp);
                check("out_inst", out_inst, mon_exp ^ KEY);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c;

        // 1: reset values, first-fetch latency, streaming rate
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h0, 20);
        reset_ni = 1'b1;
        #1;
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        step(1);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        check("t1_addr1", imem_addr, 32'h4);
        step(1);
        check("t1_valid_first", 32'(out_valid), 32'd1);
        check("t1_pc_first", out_pc, 32'h0);
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            step(1);
            c++;
        end
        check("t1_rate_cycles", 32'(c), 32'd20);
        for (int i = 0; i < 4; i++) check("t1_grant_addr", glog_q[i], 32'(4 * i));
        out_ready = 1'b0;
        exp_q.delete();

        // 2: backpressure fills exactly DEPTH entries, then drains in order
        do_reset();
        imem_gnt = 1'b1;
        reset_ni = 1'b1;
        step(10);
        check("t2_grants", 32'(glog_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_grant_addr", glog_q[i], 32'(4 * i));
        check("t2_req_full", 32'(imem_req), 32'd0);
        push_seq(32'h0, 16);
        out_ready = 1'b1;
        wait_drain("t2_drain");
        check("t2_resume_addr", glog_q[4], 32'h10);

        // 3: redirect with two live requests and two buffered entries
        do_reset();
        imem_gnt = 1'b1;
        reset_ni = 1'b1;
        step(8);
        push_seq(32'h0, 2);
        mem_hold  = 1'b1;
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(2);
        check("t3_grants", 32'(glog_q.size()), 32'd6);
        check("t3_last_grant", glog_q[5], 32'h14);
        check("t3_req_credit", 32'(imem_req), 32'd0);
        redirect_pc    = 32'h0000_0100;
        redirect_valid = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        check("t3_flushed", 32'(out_valid), 32'd0);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_req_drop", 32'(imem_req), 32'd0);
        push_seq(32'h100, 4);
        mem_hold  = 1'b0;
        out_ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_grant_after", glog_q[6], 32'h100);

        // 4: unaligned redirect target
        step(6);
        redirect_pc    = 32'h0000_0103;
        redirect_valid = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        check("t4_addr", imem_addr, 32'h100);
        check("t4_flushed", 32'(out_valid), 32'd0);
        push_seq(32'h100, 3);
        out_ready = 1'b1;
        wait_drain("t4_drain");

        // 5: redirect coincides with a response and an output handshake
        do_reset();
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h0, 8);
        reset_ni = 1'b1;
        c = 0;
        while (exp_q.size() > 1 && c < 50) begin
            step(1);
            c++;
        end
        check("t5_pre_rvalid", 32'(imem_rvalid), 32'd1);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_pc", out_pc, 32'h1C);
        redirect_pc    = 32'h0000_0200;
        redirect_valid = 1'b1;
        push_seq(32'h200, 8);
        step(1);
        redirect_valid = 1'b0;
        check("t5_flushed", 32'(out_valid), 32'd0);
        wait_drain("t5_drain");

        // 6: reset with credits exhausted; stray responses after release are ignored
        do_reset();
        imem_gnt = 1'b1;
        reset_ni = 1'b1;
        step(8);
        push_seq(32'h0, 2);
        mem_hold  = 1'b1;
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(2);
        check("t6_pending", 32'(pend_q.size()), 32'd2);
        reset_ni = 1'b0;
        imem_gnt = 1'b0;
        step(1);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_req", 32'(imem_req), 32'd0);
        step(1);
        glog_q.delete();
        reset_ni = 1'b1;
        #1;
        check("t6_restart_req", 32'(imem_req), 32'd1);
        check("t6_restart_addr", imem_addr, 32'h0);
        mem_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t6_stray_valid", 32'(out_valid), 32'd0);
        end
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h0, 4);
        wait_drain("t6_drain");
        check("t6_first_grant", glog_q[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
